pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sequences the board PLL on the 50 MHz reference clock: asserts PLL reset, waits for lock, and qualifies lock stability.
- Releases a system reset to the pixel/audio clock consumers only after the lock is qualified.
- Detects loss of lock and re-runs the sequence, with bounded retries and a sticky fault state.
- Sits beside the PLL wrapper at top level: drives its rst input and consumes its locked output.

Parameters:
RST_CYCLES, 16, PLL reset pulse width in refclk cycles (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release
LOCK_TIMEOUT_CYCLES, 50000, cycles to wait for lock before retrying (1 ms at 50 MHz)
RETRY_MAX, 3, retries allowed after a timeout before entering FAULT
CNT_W, 16, width of the shared cycle counter; must hold max(all cycle params)-1

Ports:
refclk  input  1  50 MHz reference clock; the only clock
rst  input  1  synchronous, active-high reset
pll_locked  input  1  PLL locked output; asynchronous to refclk
relock_req  input  1  single-cycle pulse; forces a full re-sequence, also the exit from FAULT
pll_rst  output  1  drives the PLL rst input
sys_rst  output  1  active-high reset for downstream logic; low only in RUN
ready  output  1  high only in RUN
fault  output  1  high only in FAULT
loss_count  output  8  saturating count of lock losses seen in RUN
state_o  output  3  current state encoding: ASSERT_RST=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4

Behaviour:
- Lock synchronizer: pll_locked passes through a 2-FF synchronizer to produce lock_s. This adds 2 cycles of latency and is the only use of pll_locked.
- All outputs are registered.
- Reset values (rst high at a refclk edge): state=ASSERT_RST, cnt=0, retry=0, pll_rst=1, sys_rst=1, ready=0, fault=0, loss_count=0, synchronizer FFs=0.
- Reset mid-operation from any state behaves identically to power-up reset.
- ASSERT_RST:
  - pll_rst=1, sys_rst=1.
  - cnt increments; at cnt==RST_CYCLES-1, go to WAIT_LOCK with cnt=0.
  - pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - If lock_s=1, go to STABILIZE with cnt=0.
  - Else, at cnt==LOCK_TIMEOUT_CYCLES-1:
    - if retry==RETRY_MAX, go to FAULT;
    - else retry+=1, go to ASSERT_RST with cnt=0.
- STABILIZE:
  - If lock_s=0, go to WAIT_LOCK with cnt=0; the timeout restarts and retry is unchanged.
  - At cnt==LOCK_STABLE_CYCLES-1 with lock_s=1, go to RUN.
  - If both conditions hit on the same cycle, lock loss wins.
- RUN:
  - sys_rst=0, ready=1, and retry is cleared on entry.
  - Loss of lock (lock_s=0): loss_count+=1, saturating at 255; go to ASSERT_RST.
  - sys_rst rises on the same edge the state leaves RUN.
- FAULT:
  - pll_rst=1, sys_rst=1, fault=1.
  - Remains until rst or relock_req.
  - relock_req: retry=0, go to ASSERT_RST.
- relock_req handling:
  - In any state other than FAULT, relock_req forces ASSERT_RST with cnt=0; retry and loss_count are unchanged.
  - relock_req has priority over every other transition except rst.
- Counter: a single CNT_W-bit counter, cleared on every state change.

Optional Feature:
- Macro: LOCK_GLITCH_FILTER_EN.
- Defined: in RUN, loss is declared only after lock_s has been 0 for 4 consecutive cycles. Shorter low pulses are ignored, the filter count resets whenever lock_s=1, and loss_count does not increment on ignored pulses. Transition latency after a real loss is therefore 4 cycles plus the 2-cycle synchronizer.
- Undefined: a single lock_s=0 cycle in RUN triggers loss, as described in Behaviour.
- Filtering applies to RUN only; other states are unaffected either way.

Test Plan:
- All scenarios use RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RETRY_MAX=2.
- Nominal bring-up: rst high 3 cycles then low, pll_locked rises 10 cycles later and stays high -> pll_rst high exactly 4 cycles; ready=1 and sys_rst=0 exactly 2+8 cycles after pll_locked is sampled high; state_o=3.
- Timeout/fault: pll_locked held 0 -> three ASSERT_RST pulses of 4 cycles each (initial plus 2 retries), then fault=1, state_o=4, pll_rst=1 steady; relock_req pulse -> state_o=0 and fault=0.
- Stabilize abort: lock high 5 cycles, low 1 cycle, then high -> returns to WAIT_LOCK, ready stays 0, release occurs 8 cycles after the second rise (+2 sync), retry unchanged.
- Loss in RUN: from RUN drop pll_locked -> sys_rst=1 and ready=0 within 3 cycles, loss_count=1, pll_rst pulses 4 cycles; 300 repeated losses -> loss_count saturates at 255.
- Glitch filter (LOCK_GLITCH_FILTER_EN defined): 3-cycle low pulse in RUN -> ready stays 1 and loss_count=0; 4-cycle low pulse -> loss declared, loss_count=1. With the macro undefined, the 3-cycle pulse causes loss.
- Reset/relock priority: assert rst during STABILIZE and relock_req during RUN on the same cycle as a loss -> rst returns everything to reset values; relock_req goes to ASSERT_RST and loss_count still increments by 1.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on refclk: pulses PLL reset, qualifies lock, releases sys_rst, and re-sequences on lock loss.
// Optional build macro LOCK_GLITCH_FILTER_EN: in RUN, lock loss needs 4 consecutive low lock_s cycles.
module pll_reset_sequencer #(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int RETRY_MAX           = 3,
    parameter int CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] loss_count,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ASSERT_RST = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABILIZE  = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } state_t;

    localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM    = RETRY_W'(RETRY_MAX);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_nx;
    logic [7:0]         loss_nx;
    logic               sync_1;
    logic               lock_s;
    logic               loss_det;
    logic               cnt_clr;

`ifdef LOCK_GLITCH_FILTER_EN
    logic [1:0] filt_cnt;

    // Counts consecutive low lock_s cycles seen in RUN; the fourth one declares loss.
    always_ff @(posedge refclk) begin
        if (rst || state != RUN || lock_s)
            filt_cnt <= '0;
        else if (filt_cnt != 2'd3)
            filt_cnt <= filt_cnt + 2'd1;
    end

    assign loss_det = (state == RUN) && !lock_s && (filt_cnt == 2'd3);
`else
    assign loss_det = (state == RUN) && !lock_s;
`endif

    always_comb begin
        state_nx = state;
        retry_nx = retry;
        loss_nx  = loss_count;

        // A loss coinciding with relock_req is still counted.
        if (loss_det && loss_count != 8'hFF)
            loss_nx = loss_count + 8'd1;

        if (relock_req) begin
            state_nx = ASSERT_RST;
            if (state == FAULT)
                retry_nx = '0;
        end else begin
            case (state)
                ASSERT_RST: begin
                    if (cnt == RST_LAST)
                        state_nx = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx = STABILIZE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry == RETRY_LIM) begin
                            state_nx = FAULT;
                        end else begin
                            retry_nx = retry + RETRY_W'(1);
                            state_nx = ASSERT_RST;
                        end
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state_nx = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nx = RUN;
                        retry_nx = '0;
                    end
                end
                RUN: begin
                    if (loss_det)
                        state_nx = ASSERT_RST;
                end
                FAULT: begin
                    state_nx = FAULT;
                end
                default: begin
                    state_nx = ASSERT_RST;
                end
            endcase
        end
    end

    assign cnt_clr = relock_req || (state_nx != state);

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_1     <= 1'b0;
            lock_s     <= 1'b0;
            state      <= ASSERT_RST;
            cnt        <= '0;
            retry      <= '0;
            loss_count <= '0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            sync_1     <= pll_locked;
            lock_s     <= sync_1;
            state      <= state_nx;
            retry      <= retry_nx;
            loss_count <= loss_nx;
            if (cnt_clr)
                cnt <= '0;
            else if (state == ASSERT_RST || state == WAIT_LOCK || state == STABILIZE)
                cnt <= cnt + CNT_W'(1);
            // Outputs decode the next state so they change on the same edge as the state.
            pll_rst <= (state_nx == ASSERT_RST) || (state_nx == FAULT);
            sys_rst <= (state_nx != RUN);
            ready   <= (state_nx == RUN);
            fault   <= (state_nx == FAULT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; follows LOCK_GLITCH_FILTER_EN like the design does.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [7:0] loss_count;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;
    int exp_loss = 0;

`ifdef LOCK_GLITCH_FILTER_EN
    localparam int LOSS_LAT = 6;
`else
    localparam int LOSS_LAT = 3;
`endif

    pll_reset_sequencer #(
        .RST_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32),
        .RETRY_MAX(2),
        .CNT_W(16)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst(pll_rst),
        .sys_rst(sys_rst),
        .ready(ready),
        .fault(fault),
        .loss_count(loss_count),
        .state_o(state_o)
    );

    always #5 refclk = ~refclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        relock_req = 1'b0;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run, n, pulses, tmo;

        // Reset values and nominal bring-up
        pll_locked = 1'b0;
        do_reset();
        check_eq("rst_state", state_o, 0);
        check_eq("rst_pll_rst", pll_rst, 1);
        check_eq("rst_sys_rst", sys_rst, 1);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_loss", loss_count, 0);
        run = 0;
        while (pll_rst && run < 20) begin
            run++;
            tick();
        end
        check_eq("pll_rst_width", run, 4);
        tick(6);
        pll_locked = 1'b1;
        tick(10);
        check_eq("bringup_ready_early", ready, 0);
        check_eq("bringup_sysrst_early", sys_rst, 1);
        tick(1);
        check_eq("bringup_ready", ready, 1);
        check_eq("bringup_sysrst", sys_rst, 0);
        check_eq("bringup_state", state_o, 3);

        // Loss of lock in RUN
        pll_locked = 1'b0;
        tick(LOSS_LAT - 1);
        check_eq("loss_sysrst_early", sys_rst, 0);
        tick(1);
        exp_loss = 1;
        check_eq("loss_sysrst", sys_rst, 1);
        check_eq("loss_ready", ready, 0);
        check_eq("loss_count1", loss_count, exp_loss);
        check_eq("loss_state", state_o, 0);
        tick(3);
        check_eq("loss_pll_rst_hi", pll_rst, 1);
        tick(1);
        check_eq("loss_pll_rst_lo", pll_rst, 0);
        check_eq("loss_wait_state", state_o, 1);
        pll_locked = 1'b1;
        wait_ready("rerun_after_loss", 40);

        // Three-cycle low pulse
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        tick(8);
`ifdef LOCK_GLITCH_FILTER_EN
        check_eq("glitch3_ready", ready, 1);
`else
        exp_loss++;
        check_eq("glitch3_ready", ready, 0);
`endif
        check_eq("glitch3_loss", loss_count, exp_loss);
        wait_ready("rerun_after_glitch3", 40);

        // Four-cycle low pulse is a real loss in either build
        pll_locked = 1'b0;
        tick(4);
        pll_locked = 1'b1;
        tick(2);
        exp_loss++;
        check_eq("glitch4_ready", ready, 0);
        check_eq("glitch4_loss", loss_count, exp_loss);
        wait_ready("rerun_after_glitch4", 40);

        // relock_req in RUN without a loss
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check_eq("relock_state", state_o, 0);
        check_eq("relock_sysrst", sys_rst, 1);
        check_eq("relock_pll_rst", pll_rst, 1);
        check_eq("relock_loss", loss_count, exp_loss);
        wait_ready("rerun_after_relock", 40);

        // rst during STABILIZE
        pll_locked = 1'b0;
        do_reset();
        tick(5);
        pll_locked = 1'b1;
        tick(4);
        check_eq("stab_state", state_o, 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("midrst_state", state_o, 0);
        check_eq("midrst_pll_rst", pll_rst, 1);
        check_eq("midrst_sys_rst", sys_rst, 1);
        check_eq("midrst_ready", ready, 0);
        check_eq("midrst_fault", fault, 0);
        check_eq("midrst_loss", loss_count, 0);

        // relock_req on the same edge as a loss in RUN
        wait_ready("run_before_relock_loss", 60);
        pll_locked = 1'b0;
        tick(LOSS_LAT - 1);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check_eq("relock_loss_state", state_o, 0);
        check_eq("relock_loss_count", loss_count, 1);

        // Stabilize abort
        pll_locked = 1'b0;
        do_reset();
        tick(6);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        check_eq("abort_state", state_o, 1);
        check_eq("abort_ready", ready, 0);
        tick(8);
        check_eq("abort_ready_early", ready, 0);
        tick(1);
        check_eq("abort_release", ready, 1);

        // Saturation of loss_count
        tmo = 0;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            n = 0;
            while (!ready && n < 60) begin tick(); n++; end
            if (!ready) tmo++;
            pll_locked = 1'b0;
            tick(4);
            pll_locked = 1'b1;
            n = 0;
            while (ready && n < 20) begin tick(); n++; end
            if (ready) tmo++;
        end
        check_eq("sat_timeouts", tmo, 0);
        check_eq("sat_loss", loss_count, 255);

        // Timeout, retries and FAULT
        pll_locked = 1'b0;
        do_reset();
        n = 0; pulses = 0; run = 0;
        while (!fault && n < 300) begin
            if (pll_rst) begin
                run++;
            end else if (run != 0) begin
                check_eq("retry_pulse_width", run, 4);
                pulses++;
                run = 0;
            end
            tick();
            n++;
        end
        check_eq("fault_cycle", n, 108);
        check_eq("fault_pulses", pulses, 3);
        check_eq("fault_state", state_o, 4);
        check_eq("fault_sys_rst", sys_rst, 1);
        check_eq("fault_ready", ready, 0);
        tick(5);
        check_eq("fault_hold_state", state_o, 4);
        check_eq("fault_hold_pll_rst", pll_rst, 1);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check_eq("fault_exit_state", state_o, 0);
        check_eq("fault_exit_fault", fault, 0);
        check_eq("fault_exit_pll_rst", pll_rst, 1);
        n = 0;
        while (!fault && n < 300) begin tick(); n++; end
        check_eq("fault_again_cycle", n, 108);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
